xor_equiv_seq: RTL and testbench
================================

Name: xor_equiv_seq

Overview:
- Self-running equivalence-check sequencer for a pair of N_IN-input, 1-output combinational implementations: the structural XOR under development (DUT) and the behavioural reference (REF).
- Drives one shared stimulus bus into both implementations and walks every input combination 0..2^N_IN-1.
- Compares the two outputs for each vector and reports pass/fail, the mismatch count and the first failing vector.
- Sits beside the gate-level blocks on the board/FPGA as the hardware equivalent of the exhaustive A/B bench.

Parameters:
- N_IN, 2, stimulus width; vectors 0..2^N_IN-1 are applied in ascending order.
- SETTLE, 2, clock cycles each vector is held before comparison; range 1..255.
- CNT_W, N_IN+1, width of fail_cnt; must be >= N_IN+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- stim  output  N_IN  stimulus vector driven to both DUT and REF; bit 0 = A, bit 1 = B.
- f_dut  input  1  DUT output.
- f_ref  input  1  REF output.
- busy  output  1  high while the sweep is running (WAIT/CMP).
- done  output  1  one-cycle pulse when the sweep ends.
- pass  output  1  1 when the last completed sweep had zero mismatches.
- fail_cnt  output  CNT_W  mismatch count of the current or last sweep.
- first_fail_vec  output  N_IN  stimulus value of the first mismatch.
- first_fail_vld  output  1  first_fail_vec is valid.

Behaviour:
- Reset, asynchronous on rst=1:
  - state=IDLE.
  - stim=0, busy=0, done=0, pass=0, fail_cnt=0, first_fail_vec=0, first_fail_vld=0.
  - Internal settle counter=0.
  - Reset mid-sweep aborts immediately to these values; no done pulse.
- FSM states: IDLE, WAIT, CMP, DONE.
- IDLE:
  - busy=0.
  - On start=1: stim<=0, fail_cnt<=0, first_fail_vld<=0, first_fail_vec<=0, pass<=0, settle counter<=0; go to WAIT.
- WAIT:
  - busy=1; stim held constant.
  - Counter increments each cycle.
  - When counter==SETTLE-1, go to CMP. WAIT therefore lasts exactly SETTLE cycles.
- CMP (one cycle): sample mismatch = f_dut ^ f_ref.
  - If mismatch: fail_cnt<=fail_cnt+1, saturating at 2^CNT_W-1.
  - If mismatch and first_fail_vld=0: first_fail_vec<=stim and first_fail_vld<=1.
  - If stim==2^N_IN-1: go to DONE. pass<=1 iff the final fail_cnt (including this cycle's mismatch) is 0.
  - Otherwise: stim<=stim+1, counter<=0, go to WAIT.
- DONE:
  - done=1 for this single cycle; busy=0; go to IDLE.
  - stim keeps the last vector until the next start.
- Latency: each vector takes SETTLE+1 cycles. The done pulse occurs 2^N_IN*(SETTLE+1)+1 cycles after the start-sampling edge, measured in cycles of the DONE state.
- start while busy, or in the DONE cycle, is ignored; there is no queuing.
- Result registers (pass, fail_cnt, first_fail_*) hold until the next accepted start.
- stim is fully registered, so there are no glitches on the shared bus.

Optional Feature:
- Macro: XOR_EQUIV_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CMP ends the sweep immediately.
  - fail_cnt=1 and first_fail_* are captured.
  - Next state is DONE, with pass=0 and done pulsed.
  - stim holds the failing vector for probing.
- Undefined: the full sweep always runs and counts all mismatches (default).

Test Plan:
- Equivalent pair (f_dut=f_ref=stim[0]^stim[1]), N_IN=2, SETTLE=2, single start pulse:
  - stim steps 0,1,2,3, each held 3 cycles.
  - busy high for 12 cycles, then done for 1 cycle.
  - pass=1, fail_cnt=0, first_fail_vld=0.
- DUT modelled as OR (mismatch only at stim=3):
  - pass=0, fail_cnt=1, first_fail_vec=2'b11, first_fail_vld=1.
- DUT modelled as NOT XOR (all 4 vectors mismatch):
  - fail_cnt=4, first_fail_vec=0.
  - With XOR_EQUIV_STOP_ON_FAIL_EN defined: done 4 cycles after start (3 WAIT/CMP cycles + DONE), fail_cnt=1, stim stays 0.
- start re-pulsed mid-sweep at stim=1:
  - Ignored; the sweep completes normally with the same 12-cycle busy window.
  - A second start after done clears the results and reruns the sweep.
- rst asserted asynchronously at stim=2 in WAIT:
  - All outputs are 0 in the same cycle, with no done pulse.
  - After rst is released and start is given, the full sweep restarts from stim=0.
- SETTLE=1, N_IN=3, equivalent 3-input parity pair:
  - 8 vectors at 2 cycles each; busy for 16 cycles.
  - pass=1, fail_cnt=0 (CNT_W=4).

Source files
------------

// File: rtl/xor_equiv_seq.sv
// Exhaustive equivalence-check sequencer: sweeps every stimulus vector into a DUT/REF pair
// and compares their outputs. Optional macro XOR_EQUIV_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module xor_equiv_seq #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = N_IN + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic              f_dut,
  input  logic              f_ref,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic              first_fail_vld
);

  localparam int unsigned SET_W = 8;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
`ifdef XOR_EQUIV_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CMP, S_DONE} state_t;

  state_t            state, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [N_IN-1:0]   stim_d, first_fail_vec_d;
  logic [CNT_W-1:0]  fail_cnt_d, fail_inc;
  logic              busy_d, done_d, pass_d, first_fail_vld_d;
  logic              mismatch, last_vec;

  assign mismatch = f_dut ^ f_ref;
  assign last_vec = &stim;
  // Saturating increment so a long sweep cannot wrap back to zero.
  assign fail_inc = (&fail_cnt) ? fail_cnt : fail_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      settle_q       <= '0;
      stim           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_cnt       <= '0;
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      state          <= state_d;
      settle_q       <= settle_d;
      stim           <= stim_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      fail_cnt       <= fail_cnt_d;
      first_fail_vec <= first_fail_vec_d;
      first_fail_vld <= first_fail_vld_d;
    end
  end

  // busy/done are computed for the next state so the registered copies track the state.
  always_comb begin
    state_d          = state;
    settle_d         = settle_q;
    stim_d           = stim;
    busy_d           = 1'b0;
    done_d           = 1'b0;
    pass_d           = pass;
    fail_cnt_d       = fail_cnt;
    first_fail_vec_d = first_fail_vec;
    first_fail_vld_d = first_fail_vld;
    case (state)
      S_IDLE: begin
        if (start) begin
          stim_d           = '0;
          settle_d         = '0;
          pass_d           = 1'b0;
          fail_cnt_d       = '0;
          first_fail_vec_d = '0;
          first_fail_vld_d = 1'b0;
          busy_d           = 1'b1;
          state_d          = S_WAIT;
        end
      end
      S_WAIT: begin
        busy_d   = 1'b1;
        settle_d = settle_q + SET_W'(1);
        if (settle_q == SETTLE_LAST) state_d = S_CMP;
      end
      S_CMP: begin
        if (mismatch) begin
          fail_cnt_d = fail_inc;
          if (!first_fail_vld) begin
            first_fail_vec_d = stim;
            first_fail_vld_d = 1'b1;
          end
        end
        if (last_vec || (STOP_ON_FAIL && mismatch)) begin
          pass_d  = (fail_cnt_d == '0);
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          stim_d   = stim + N_IN'(1);
          settle_d = '0;
          busy_d   = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_xor_equiv_seq.sv
// Directed bench for xor_equiv_seq: equivalent, OR, and inverted-XOR pairs, ignored restart,
// async reset mid-sweep, and a 3-input SETTLE=1 instance.
module tb_xor_equiv_seq;

  logic       clk, rst, start, start3;
  logic [1:0] stim, first_fail_vec;
  logic       f_dut, f_ref, busy, done, pass, first_fail_vld;
  logic [2:0] fail_cnt;
  logic [2:0] stim3, first_fail_vec3;
  logic       f3, busy3, done3, pass3, first_fail_vld3;
  logic [3:0] fail_cnt3;
  int         mode;
  int         total, bad;
  logic [1:0] stim_log [0:127];

  xor_equiv_seq u_dut (
    .clk(clk), .rst(rst), .start(start), .stim(stim), .f_dut(f_dut), .f_ref(f_ref),
    .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
    .first_fail_vec(first_fail_vec), .first_fail_vld(first_fail_vld)
  );

  xor_equiv_seq #(.N_IN(3), .SETTLE(1), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .stim(stim3), .f_dut(f3), .f_ref(f3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_cnt(fail_cnt3),
    .first_fail_vec(first_fail_vec3), .first_fail_vld(first_fail_vld3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: XOR (equivalent), 1: OR, 2: XNOR
  assign f_ref = stim[0] ^ stim[1];
  always_comb begin
    case (mode)
      1:       f_dut = stim[0] | stim[1];
      2:       f_dut = ~(stim[0] ^ stim[1]);
      default: f_dut = stim[0] ^ stim[1];
    endcase
  end
  assign f3 = ^stim3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Pulse start across one edge, then log one sample per cycle until done (bounded).
  task automatic sweep(input int kick_at, output int nbusy, output int tdone);
    nbusy = 0;
    tdone = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = (c == kick_at);
      if (busy) nbusy++;
      stim_log[c] = stim;
      if (done) begin
        tdone = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int nb, td, seen;
    logic [2:0] s15;
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; start3 = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_stim", 32'(stim), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_fail_cnt", 32'(fail_cnt), 0);
    chk("rst_ff_vld", 32'(first_fail_vld), 0);
    rst = 1'b0;

    // Equivalent pair
    mode = 0;
    sweep(0, nb, td);
    chk("eq_busy_cycles", nb, 12);
    chk("eq_done_cycle", td, 13);
    chk("eq_stim_c1", 32'(stim_log[1]), 0);
    chk("eq_stim_c3", 32'(stim_log[3]), 0);
    chk("eq_stim_c4", 32'(stim_log[4]), 1);
    chk("eq_stim_c7", 32'(stim_log[7]), 2);
    chk("eq_stim_c10", 32'(stim_log[10]), 3);
    chk("eq_pass", 32'(pass), 1);
    chk("eq_fail_cnt", 32'(fail_cnt), 0);
    chk("eq_ff_vld", 32'(first_fail_vld), 0);
    @(negedge clk);
    chk("eq_done_one_cycle", 32'(done), 0);
    chk("eq_stim_hold", 32'(stim), 3);

    // OR as DUT: only vector 3 differs
    mode = 1;
    sweep(0, nb, td);
    chk("or_done_cycle", td, 13);
    chk("or_pass", 32'(pass), 0);
    chk("or_fail_cnt", 32'(fail_cnt), 1);
    chk("or_ff_vec", 32'(first_fail_vec), 3);
    chk("or_ff_vld", 32'(first_fail_vld), 1);

    // XNOR as DUT: every vector differs
    mode = 2;
    sweep(0, nb, td);
`ifdef XOR_EQUIV_STOP_ON_FAIL_EN
    chk("nx_done_cycle", td, 4);
    chk("nx_busy_cycles", nb, 3);
    chk("nx_fail_cnt", 32'(fail_cnt), 1);
    chk("nx_stim_hold", 32'(stim), 0);
`else
    chk("nx_done_cycle", td, 13);
    chk("nx_busy_cycles", nb, 12);
    chk("nx_fail_cnt", 32'(fail_cnt), 4);
`endif
    chk("nx_ff_vec", 32'(first_fail_vec), 0);
    chk("nx_ff_vld", 32'(first_fail_vld), 1);
    chk("nx_pass", 32'(pass), 0);

    // Equivalent rerun with start re-pulsed at stim=1; results from XNOR run must clear
    mode = 0;
    sweep(4, nb, td);
    chk("kick_busy_cycles", nb, 12);
    chk("kick_done_cycle", td, 13);
    chk("kick_pass", 32'(pass), 1);
    chk("kick_fail_cnt", 32'(fail_cnt), 0);
    chk("kick_ff_vld", 32'(first_fail_vld), 0);

    // Async reset while in WAIT at stim=2
`ifdef XOR_EQUIV_STOP_ON_FAIL_EN
    mode = 0;
`else
    mode = 2;
`endif
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_stim", 32'(stim), 2);
    chk("pre_rst_busy", 32'(busy), 1);
`ifndef XOR_EQUIV_STOP_ON_FAIL_EN
    chk("pre_rst_fail_cnt", 32'(fail_cnt), 2);
`endif
    #2 rst = 1'b1;
    #1;
    chk("arst_stim", 32'(stim), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_fail_cnt", 32'(fail_cnt), 0);
    chk("arst_ff_vld", 32'(first_fail_vld), 0);
    chk("arst_ff_vec", 32'(first_fail_vec), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("arst_no_done", seen, 0);
    mode = 0;
    sweep(0, nb, td);
    chk("arst_rerun_stim_c1", 32'(stim_log[1]), 0);
    chk("arst_rerun_done", td, 13);
    chk("arst_rerun_pass", 32'(pass), 1);

    // 3-input parity pair, SETTLE=1
    nb = 0; td = 0; s15 = '0;
    @(negedge clk);
    start3 = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (busy3) nb++;
      if (c == 15) s15 = stim3;
      if (done3) begin
        td = c;
        break;
      end
    end
    chk("n3_busy_cycles", nb, 16);
    chk("n3_done_cycle", td, 17);
    chk("n3_stim_c15", 32'(s15), 7);
    chk("n3_pass", 32'(pass3), 1);
    chk("n3_fail_cnt", 32'(fail_cnt3), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
